// File: rtl/pc_status_sequencer.sv
// PC, latched NZCV status and multi-cycle state register fed by the control-unit mux.
// Optional macro PC_PERF_COUNTERS_EN adds retired/taken instruction counters.
module pc_status_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [30:0] controlword,
  input  logic [1:0]  next_state,
  input  logic [63:0] K,
  input  logic [63:0] pc_in,
  input  logic [3:0]  alu_flags,
  input  logic        alu_zero,
  input  logic        stall,
  output logic [63:0] pc,
  output logic [63:0] pc_plus4,
  output logic [63:0] pc_bus,
  output logic        pc_bus_en,
  output logic [4:0]  status,
  output logic [1:0]  state,
  output logic        misalign
`ifdef PC_PERF_COUNTERS_EN
  ,
  output logic [31:0] retired,
  output logic [31:0] taken
`endif
);

  localparam logic [63:0] STEP = 64'(PC_STEP);

  logic [1:0]  psel;
  logic        en_pc;
  logic        pcsel;
  logic        sl;
  logic [63:0] pc_reg;
  logic [63:0] pc_next;
  logic [63:0] seq_pc;
  logic [63:0] off;
  logic [3:0]  flags_reg;  // {V,C,N,Z}, same order as alu_flags
  logic [1:0]  state_reg;
  logic        misalign_reg;
  logic        misalign_next;
  logic        unused_cw;

  assign psel      = controlword[30:29];
  assign en_pc     = controlword[3];
  assign pcsel     = controlword[1];
  assign sl        = controlword[0];
  assign unused_cw = ^{controlword[28:4], controlword[2]};

  always_comb begin
    seq_pc        = pc_reg + STEP;
    off           = (pcsel ? K : pc_in) << 2;
    pc_next       = pc_reg;
    misalign_next = misalign_reg;
    case (psel)
      2'b01: pc_next = seq_pc;
      2'b10: begin
        pc_next       = {pc_in[63:2], 2'b00};
        misalign_next = misalign_reg | (|pc_in[1:0]);
      end
      2'b11: pc_next = seq_pc + off;
      default: pc_next = pc_reg;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_reg       <= RESET_PC;
      flags_reg    <= 4'b0000;
      state_reg    <= 2'b00;
      misalign_reg <= 1'b0;
    end else if (!stall) begin
      pc_reg       <= pc_next;
      state_reg    <= next_state;
      misalign_reg <= misalign_next;
      if (sl) flags_reg <= alu_flags;
    end
  end

`ifdef PC_PERF_COUNTERS_EN
  logic [31:0] retired_reg;
  logic [31:0] taken_reg;
  logic        branch_taken;

  assign branch_taken = psel[1] && (pc_next != seq_pc);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_reg <= 32'd0;
      taken_reg   <= 32'd0;
    end else if (!stall) begin
      if (next_state == 2'b00) retired_reg <= retired_reg + 32'd1;
      if (branch_taken)        taken_reg   <= taken_reg + 32'd1;
    end
  end

  assign retired = retired_reg;
  assign taken   = taken_reg;
`endif

  // Bus drive is gated per bit so the datapath sees zero when the PC is not selected.
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_pc_bus
      assign pc_bus[gi] = pc_reg[gi] & en_pc;
    end
  endgenerate

  assign pc        = pc_reg;
  assign pc_plus4  = seq_pc;
  assign pc_bus_en = en_pc;
  assign status    = {flags_reg[3], flags_reg[2], flags_reg[0], flags_reg[1], alu_zero};
  assign state     = state_reg;
  assign misalign  = misalign_reg;

endmodule

// File: tb/tb_pc_status_sequencer.sv
// Scoreboard bench for pc_status_sequencer: driver pushes model results, monitor compares after each edge.
// Build with PC_PERF_COUNTERS_EN defined to also check the retired/taken counters.
module tb_pc_status_sequencer;

  logic        clock;
  logic        reset;
  logic [30:0] controlword;
  logic [1:0]  next_state;
  logic [63:0] k;
  logic [63:0] pc_in;
  logic [3:0]  alu_flags;
  logic        alu_zero;
  logic        stall;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic [63:0] pc_bus;
  logic        pc_bus_en;
  logic [4:0]  status;
  logic [1:0]  state;
  logic        misalign;
  logic [31:0] retired;
  logic [31:0] taken;

  pc_status_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .controlword(controlword),
    .next_state (next_state),
    .K          (k),
    .pc_in      (pc_in),
    .alu_flags  (alu_flags),
    .alu_zero   (alu_zero),
    .stall      (stall),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .pc_bus     (pc_bus),
    .pc_bus_en  (pc_bus_en),
    .status     (status),
    .state      (state),
    .misalign   (misalign)
`ifdef PC_PERF_COUNTERS_EN
    ,
    .retired    (retired),
    .taken      (taken)
`endif
  );

`ifndef PC_PERF_COUNTERS_EN
  assign retired = 32'd0;
  assign taken   = 32'd0;
`endif

  typedef struct {
    logic [63:0] pc;
    logic [63:0] pc4;
    logic [63:0] bus;
    logic        bus_en;
    logic [4:0]  status;
    logic [1:0]  state;
    logic        mis;
    logic [31:0] ret;
    logic [31:0] tkn;
  } exp_t;

  exp_t exp_q[$];

  int vectors    = 0;
  int miscompares = 0;

  // Architectural model
  logic [63:0] m_pc;
  logic        m_v, m_c, m_n, m_z;
  logic [1:0]  m_state;
  logic        m_mis;
  logic [31:0] m_ret, m_tkn;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_v = 0; m_c = 0; m_n = 0; m_z = 0;
    m_state = 2'b00; m_mis = 0; m_ret = 0; m_tkn = 0;
  endtask

  task automatic check_reset_now();
    check("rst_pc",       pc,                   64'h0);
    check("rst_pc_plus4", pc_plus4,             64'h4);
    check("rst_status",   64'(status[4:1]),     64'h0);
    check("rst_state",    64'(state),           64'h0);
    check("rst_misalign", 64'(misalign),        64'h0);
`ifdef PC_PERF_COUNTERS_EN
    check("rst_retired",  64'(retired),         64'h0);
    check("rst_taken",    64'(taken),           64'h0);
`endif
  endtask

  task automatic apply(input logic [1:0] psel, input logic pcsel, input logic sl,
                       input logic en, input logic [1:0] ns, input logic [63:0] kv,
                       input logic [63:0] pin, input logic [3:0] flags, input logic zi,
                       input logic stl);
    logic [30:0] cw;
    logic [63:0] seq, off, tgt;
    exp_t e;
    @(negedge clock);
    cw = 31'($urandom);
    cw[30:29] = psel; cw[3] = en; cw[1] = pcsel; cw[0] = sl;
    controlword = cw; next_state = ns; k = kv; pc_in = pin;
    alu_flags = flags; alu_zero = zi; stall = stl;
    if (!stl) begin
      seq = m_pc + 64'd4;
      off = (pcsel ? kv : pin) * 64'd4;
      case (psel)
        2'b00: tgt = m_pc;
        2'b01: tgt = seq;
        2'b10: tgt = pin - 64'(pin[1:0]);
        default: tgt = seq + off;
      endcase
      if (psel >= 2'b10 && tgt != seq) m_tkn = m_tkn + 1;
      if (ns == 2'b00) m_ret = m_ret + 1;
      if (psel == 2'b10 && pin[1:0] != 2'b00) m_mis = 1;
      if (sl) {m_v, m_c, m_n, m_z} = flags;
      m_pc = tgt;
      m_state = ns;
    end
    e.pc = m_pc;
    e.pc4 = m_pc + 64'd4;
    e.bus = en ? m_pc : 64'h0;
    e.bus_en = en;
    e.status = {m_v, m_c, m_z, m_n, zi};
    e.state = m_state;
    e.mis = m_mis;
    e.ret = m_ret;
    e.tkn = m_tkn;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry per clock edge, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pc",        pc,               e.pc);
        check("pc_plus4",  pc_plus4,         e.pc4);
        check("pc_bus",    pc_bus,           e.bus);
        check("pc_bus_en", 64'(pc_bus_en),   64'(e.bus_en));
        check("status",    64'(status),      64'(e.status));
        check("state",     64'(state),       64'(e.state));
        check("misalign",  64'(misalign),    64'(e.mis));
`ifdef PC_PERF_COUNTERS_EN
        check("retired",   64'(retired),     64'(e.ret));
        check("taken",     64'(taken),       64'(e.tkn));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cycles;
    reset = 1'b0; stall = 1'b1; controlword = '0; next_state = 2'b00;
    k = '0; pc_in = '0; alu_flags = '0; alu_zero = 1'b0;
    model_reset();
    #3;
    check_reset_now();
    @(negedge clock);
    reset = 1'b1;

    // Sequential fetch
    repeat (3) apply(2'b01, 0, 0, 1, 2'b00, 64'h0, 64'h0, 4'h0, 0, 0);
    // Register jump then PC-relative branch
    apply(2'b10, 0, 0, 0, 2'b00, 64'h0, 64'h100, 4'h0, 0, 0);
    apply(2'b11, 1, 0, 0, 2'b00, 64'h10, 64'h0, 4'h0, 0, 0);
    // Wrap at the top of the address space
    apply(2'b10, 0, 0, 0, 2'b00, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 4'h0, 0, 0);
    apply(2'b01, 0, 0, 1, 2'b00, 64'h0, 64'h0, 4'h0, 0, 0);
    // Status latch and hold
    apply(2'b00, 0, 1, 0, 2'b00, 64'h0, 64'h0, 4'b1011, 1, 0);
    apply(2'b00, 0, 0, 0, 2'b00, 64'h0, 64'h0, 4'b0100, 0, 0);
    // Misaligned register target, sticky
    apply(2'b10, 0, 0, 1, 2'b00, 64'h0, 64'h2006, 4'h0, 0, 0);
    apply(2'b01, 0, 0, 0, 2'b00, 64'h0, 64'h0, 4'h0, 0, 0);
    apply(2'b11, 0, 0, 1, 2'b11, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 0, 0);
    // Stall freezes everything
    repeat (2) apply(2'b01, 0, 1, 1, 2'b01, 64'h0, 64'h0, 4'b1111, 0, 1);

    // Asynchronous reset between edges
    @(negedge clock);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_now();
    @(negedge clock);
    reset = 1'b1;

    // Two-state instruction, taken branch, then not-taken conditional
    apply(2'b00, 0, 0, 0, 2'b01, 64'h0, 64'h0, 4'h0, 0, 0);
    apply(2'b11, 1, 0, 0, 2'b00, 64'h3, 64'h0, 4'h0, 0, 0);
    apply(2'b01, 0, 0, 0, 2'b00, 64'h0, 64'h0, 4'h0, 0, 0);
    // Branch whose target equals pc+4 is not counted as taken
    apply(2'b11, 1, 0, 0, 2'b00, 64'h0, 64'h0, 4'h0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [63:0] kv, pin;
      kv  = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 64));
      pin = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 4095));
      apply(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
            kv, pin, 4'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0));
    end

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(posedge clock);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_status_sequencer.md
Name: pc_status_sequencer

Overview:
- Sequential consumer of the 31-bit control word, next-state and K outputs driven by the per-opcode control units (B, B.cond, CBZ, ALU, LDUR/STUR).
- Holds the architectural PC, the latched NZCV status register and the 2-bit multi-cycle state register.
- Feeds status and state back to the control units and PC to instruction memory and the datapath bus.
- Sits between the control-unit mux and the datapath/instruction ROM.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- PC_STEP, 4, byte increment for sequential fetch.

Ports:
- clock  in  1  rising-edge system clock
- reset  in  1  asynchronous, active-low reset
- controlword  in  31  {Psel[30:29], DA[28:24], SA[23:19], SB[18:14], Fsel[13:9], regW[8], ramW[7], EN_MEM[6], EN_ALU[5], EN_B[4], EN_PC[3], Bsel[2], PCsel[1], SL[0]}
- next_state  in  2  state for next cycle, from the active control unit
- K  in  64  constant from the control unit (word offset)
- pc_in  in  64  register value from A bus (BR target / offset source)
- alu_flags  in  4  {V,C,N,Z} from ALU this cycle
- alu_zero  in  1  ALU-result-zero, used for CBZ/CBNZ
- stall  in  1  freeze all registers this cycle
- pc  out  64  current PC, to instruction memory
- pc_plus4  out  64  pc + PC_STEP, combinational, for BL link
- pc_bus  out  64  equals pc when EN_PC=1, else 0
- pc_bus_en  out  1  = controlword[3]
- status  out  5  {V,C,Z,N,ZI}: V,C,Z,N registered; ZI = alu_zero passthrough
- state  out  2  registered state
- misalign  out  1  sticky: register jump target had bits[1:0]!=0

Behaviour:
- Reset (async, reset=0): pc=RESET_PC, V=C=Z=N=0, state=2'b00, misalign=0, counters=0. Reset active mid-instruction aborts it. Next fetch is from RESET_PC in state 00.
- All updates occur on the rising clock edge with reset=1 and stall=0. With stall=1, every register holds and outputs are unchanged.
- State register: state <= next_state each unstalled edge; no other legal checks. 2'b11 is passed through unchanged.
- PC update per Psel, with off = (PCsel ? K : pc_in) << 2, arithmetic mod 2^64 (silent wrap, e.g. FFFF_FFFF_FFFF_FFFC+4 -> 0):
  - 00: hold
  - 01: pc <= pc + PC_STEP
  - 10: pc <= {pc_in[63:2],2'b00}; if pc_in[1:0]!=0, misalign <= 1 (sticky until reset)
  - 11: pc <= pc + PC_STEP + off
- K is used as given; sign extension is the control unit's job. Shift discards off's top 2 bits.
- Status: if SL=1, {V,C,N,Z} <= alu_flags; else hold. ZI never registered.
- Same-edge SL and Psel=11: PC decision uses the pre-edge status already consumed by the control unit; new flags are visible the next cycle.
- pc_plus4 and pc_bus track registered pc combinationally; zero added latency.
- Multi-cycle instructions with Psel=00 on intermediate states keep pc stable until the final state.

Optional Feature:
- Macro PC_PERF_COUNTERS_EN. When defined, adds outputs retired[31:0] and taken[31:0].
- retired: increments on each unstalled edge with next_state==2'b00.
- taken: increments on each unstalled edge with Psel==2'b10 or 2'b11 and target != pc+PC_STEP.
- Both wrap mod 2^32 and are cleared by reset.
- Without the macro, the ports and logic are absent and the block is otherwise identical.

Test Plan:
- Reset release, 3 edges of Psel=01 -> pc 0,4,8,12; state 00; status 5'b00000; misalign 0.
- pc=0x100, Psel=11, PCsel=1, K=0x10 -> pc=0x144. Then Psel=01 with pc at 64'hFFFF_FFFF_FFFF_FFFC -> pc wraps to 0.
- SL=1, alu_flags=4'b1011 -> next cycle status={V1,C0,Z1,N1,ZI=alu_zero}. SL=0 with new flags -> status unchanged.
- Psel=10, pc_in=0x2006 -> pc=0x2004, misalign=1 and stays 1 after later Psel=01; EN_PC=1 -> pc_bus=pc, pc_bus_en=1; EN_PC=0 -> pc_bus=0.
- stall=1 for 2 edges with Psel=01, SL=1, next_state=01 -> pc, status, state unchanged. Then reset pulsed mid-stall asynchronously -> pc=RESET_PC immediately, before any clock edge.
- With PC_PERF_COUNTERS_EN: 2-state sequence (next_state 01 then 00) plus taken branch -> retired=1, taken=1; a not-taken B.cond (Psel=01) leaves taken unchanged.
